// File: rtl/aes_spi_link.sv
// SPI slave front end for an AES core: shifts in {plaintext,key}, launches the core,
// captures the result and shifts it back out on a later frame.
module aes_spi_link #(
    parameter int KEY_W = 128,
    parameter int BLK_W = 128,
    parameter int CPOL  = 0,
    parameter int CPHA  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sck,
    input  logic             cs_n,
    input  logic             sdi,
    output logic             sdo,
    output logic [KEY_W-1:0] key,
    output logic [BLK_W-1:0] plaintext,
    output logic             start,
    input  logic             done,
    input  logic [BLK_W-1:0] result,
    output logic             rdy,
    output logic             err
);

    // state   | meaning
    // IDLE    | no frame open, waiting for cs_n fall
    // RX      | shifting {plaintext,key} in on sample edges
    // WAIT    | core launched; capture result on first done, hold until cs_n fall
    // TX      | shifting captured result out on sdo

    localparam int N  = KEY_W + BLK_W;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic          SCK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_WAIT, ST_TX} state_t;

    state_t          state_q, state_d;
    logic            sck_s1_q, sck_s2_q, sck_prev_q;
    logic            cs_s1_q, cs_s2_q, cs_prev_q;
    logic            sdi_s1_q, sdi_s2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [BLK_W-1:0] tx_q, tx_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic            rdy_q, rdy_d;

    logic            sck_rise, sck_fall, lead_edge, trail_edge;
    logic            sample_edge, shift_edge, cs_fall, cs_rise;
    logic            cnt_adv, rx_full;
    logic [CW-1:0]   cnt_inc;

    assign sck_rise   = sck_s2_q & ~sck_prev_q;
    assign sck_fall   = ~sck_s2_q & sck_prev_q;
    assign lead_edge  = (CPOL == 0) ? sck_rise : sck_fall;
    assign trail_edge = (CPOL == 0) ? sck_fall : sck_rise;
    // gating on the delayed cs lets a sample coincident with cs_n rise still count
    assign sample_edge = ~cs_prev_q & ((CPHA == 0) ? lead_edge : trail_edge);
    assign shift_edge  = ~cs_prev_q & ((CPHA == 0) ? trail_edge : lead_edge);
    assign cs_fall     = cs_prev_q & ~cs_s2_q;
    assign cs_rise     = ~cs_prev_q & cs_s2_q;

    assign cnt_adv = sample_edge & (cnt_q != N_CNT);
    assign cnt_inc = cnt_q + {{(CW-1){1'b0}}, cnt_adv};
    assign rx_full = (cnt_inc == N_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sck_s1_q   <= SCK_IDLE;
            sck_s2_q   <= SCK_IDLE;
            sck_prev_q <= SCK_IDLE;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_prev_q  <= 1'b1;
            sdi_s1_q   <= 1'b0;
            sdi_s2_q   <= 1'b0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= '0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_s1_q   <= sck;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            cs_s1_q    <= cs_n;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            sdi_s1_q   <= sdi;
            sdi_s2_q   <= sdi_s1_q;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            start_q    <= start_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_RX;
            ST_RX:   if (cs_rise) state_d = rx_full ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (cs_fall) state_d = rdy_q ? ST_TX : ST_RX;
            ST_TX:   if (cs_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        rdy_d   = rdy_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) cnt_d = '0;
            end
            ST_RX: begin
                if (cnt_adv) begin
                    shreg_d = {shreg_q[N-2:0], sdi_s2_q};
                    cnt_d   = cnt_inc;
                end
                if (cs_rise) begin
                    start_d = rx_full;
                    err_d   = ~rx_full;
                end
            end
            ST_WAIT: begin
                if (cs_fall) begin
                    cnt_d = '0;
                end else if (done && !rdy_q) begin
                    tx_d  = result;
                    rdy_d = 1'b1;
                end
            end
            ST_TX: begin
                if (cnt_adv) cnt_d = cnt_inc;
                // with CPHA=1 the first shift edge only launches the MSB already on sdo
                if (shift_edge && cnt_q != '0) tx_d = {tx_q[BLK_W-2:0], 1'b0};
                if (cs_rise) rdy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign sdo       = (state_q == ST_TX) && !cs_n && tx_q[BLK_W-1];
    assign key       = shreg_q[KEY_W-1:0];
    assign plaintext = shreg_q[N-1:KEY_W];
    assign start     = start_q;
    assign err       = err_q;
    assign rdy       = rdy_q;

endmodule
